// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S receiver: resynchronises an external I2S stream into clk and emits stereo sample pairs
//
// Ports:
//   clk          system clock; all logic on the rising edge
//   rst          synchronous active-high reset
//   in_sck       I2S bit clock (asynchronous)
//   in_ws        I2S word select, 0 = left, 1 = right (asynchronous)
//   in_sd        I2S serial data, MSB first (asynchronous)
//   left_sample  last committed left word
//   right_sample last committed right word
//   sample_valid one-cycle pulse when a new stereo pair is loaded
//   frame_err    one-cycle pulse when a committed word was short (LSBs zero-filled)
module i2s_rx #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_sck,
  input  logic                  in_ws,
  input  logic                  in_sd,
  output logic [DATA_WIDTH-1:0] left_sample,
  output logic [DATA_WIDTH-1:0] right_sample,
  output logic                  sample_valid,
  output logic                  frame_err
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DATA_WIDTH);

  // Two-flop synchronizers, plus a third sck copy for edge detection
  logic sck_s1, sck_s2, sck_d;
  logic ws_s1, ws_s2;
  logic sd_s1, sd_s2;

  logic [DATA_WIDTH-1:0] word;
  logic [CW-1:0]         bit_cnt;
  logic                  ws_prev;
  // primed: ws_prev holds a real sampled ws (not the reset value), so the
  // very first rise after reset can never be mistaken for a ws change
  logic                  primed;
  logic                  aligned;
  logic [DATA_WIDTH-1:0] pend_left;
  logic                  left_seen;

  logic                  sck_rise;
  logic [DATA_WIDTH-1:0] word_in;
  logic [CW-1:0]         cnt_next;
  logic                  word_end;
  logic                  short_word;
  logic                  commit_left;
  logic                  commit_right;

  assign sck_rise = sck_s2 & ~sck_d;

  // Word register with the current sd bit merged in; bits past W are dropped
  always_comb begin
    word_in = word;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (int'(bit_cnt) == DATA_WIDTH - 1 - i) begin
        word_in[i] = sd_s2;
      end
    end
    cnt_next = (bit_cnt == FULL_CNT) ? bit_cnt : bit_cnt + CW'(1);
  end

  // The ws-change rise still carries the last bit of the ending word
  assign word_end     = sck_rise & primed & (ws_s2 != ws_prev);
  assign short_word   = (cnt_next != FULL_CNT);
  assign commit_left  = word_end & aligned & ~ws_prev;
  assign commit_right = word_end & aligned & ws_prev & left_seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_s1       <= 1'b0;
      sck_s2       <= 1'b0;
      sck_d        <= 1'b0;
      ws_s1        <= 1'b0;
      ws_s2        <= 1'b0;
      sd_s1        <= 1'b0;
      sd_s2        <= 1'b0;
      word         <= '0;
      bit_cnt      <= '0;
      ws_prev      <= 1'b0;
      primed       <= 1'b0;
      aligned      <= 1'b0;
      pend_left    <= '0;
      left_seen    <= 1'b0;
      left_sample  <= '0;
      right_sample <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sck_s1       <= in_sck;
      sck_s2       <= sck_s1;
      sck_d        <= sck_s2;
      ws_s1        <= in_ws;
      ws_s2        <= ws_s1;
      sd_s1        <= in_sd;
      sd_s2        <= sd_s1;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;

      if (sck_rise) begin
        primed  <= 1'b1;
        ws_prev <= ws_s2;
        if (word_end) begin
          // Next rise carries the MSB of the new word (one-bit ws lead)
          word    <= '0;
          bit_cnt <= '0;
          aligned <= 1'b1;
          if (commit_left) begin
            pend_left <= word_in;
            left_seen <= 1'b1;
            frame_err <= short_word;
          end
          if (commit_right) begin
            left_sample  <= pend_left;
            right_sample <= word_in;
            sample_valid <= 1'b1;
            left_seen    <= 1'b0;
            frame_err    <= short_word;
          end
        end else begin
          word    <= word_in;
          bit_cnt <= cnt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - self-checking bench for i2s_rx
module tb_i2s_rx;

  localparam int W = 16;

  typedef struct {
    logic        ch;
    int          len;
    logic [31:0] val;
  } slot_t;

  logic          clk;
  logic          rst;
  logic          in_sck;
  logic          in_ws;
  logic          in_sd;
  logic [W-1:0]  left_sample;
  logic [W-1:0]  right_sample;
  logic          sample_valid;
  logic          frame_err;

  i2s_rx #(.DATA_WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_sck       (in_sck),
    .in_ws        (in_ws),
    .in_sd        (in_sd),
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .sample_valid (sample_valid),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  slot_t       slots[$];
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          got_err;
  int          exp_err;
  int          errors;
  int          checks;
  bit          rand_sck;

  int   cyc = 0;
  int   r2l_cyc = 0;
  logic tb_sck_prev = 1'b0;
  logic tb_ws_prev = 1'b0;

  // Cycle index of the edge where in_sck is first seen high on a right->left rise
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (in_sck && !tb_sck_prev) begin
      if (!in_ws && tb_ws_prev) r2l_cyc = cyc;
      tb_ws_prev = in_ws;
    end
    tb_sck_prev = in_sck;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (sample_valid) begin
        got_q.push_back({left_sample, right_sample});
        lat_q.push_back(cyc - r2l_cyc);
      end
      if (frame_err) got_err = got_err + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    assert (got === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic add_slot(input logic ch, input int len, input logic [31:0] v);
    slot_t       s;
    logic [63:0] m;
    m     = (64'd1 << len) - 64'd1;
    s.ch  = ch;
    s.len = len;
    s.val = v & m[31:0];
    slots.push_back(s);
  endtask

  task automatic drive_bit(input logic ws, input logic b);
    int lo;
    int hi;
    lo = rand_sck ? int'($urandom_range(2, 5)) : 4;
    hi = rand_sck ? int'($urandom_range(2, 5)) : 4;
    in_sck = 1'b0;
    in_ws  = ws;
    in_sd  = b;
    repeat (lo) @(negedge clk);
    in_sck = 1'b1;
    repeat (hi) @(negedge clk);
  endtask

  // ws leads sd by one bit: the last bit of each slot goes out with the next slot's ws
  task automatic run_stream();
    logic chs[$];
    logic bits[$];
    logic ws;
    foreach (slots[i]) begin
      for (int k = slots[i].len - 1; k >= 0; k--) begin
        chs.push_back(slots[i].ch);
        bits.push_back(slots[i].val[k]);
      end
    end
    for (int n = 0; n < chs.size(); n++) begin
      ws = (n + 1 < chs.size()) ? chs[n+1] : chs[n];
      drive_bit(ws, bits[n]);
    end
    in_sck = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  function automatic logic [15:0] exp_word(input int len, input logic [31:0] v);
    if (len >= W) return 16'(v >> (len - W));
    return 16'(v << (W - len));
  endfunction

  // Slot 0 only aligns, the final slot never ends; everything between is judged
  task automatic build_expect();
    logic [15:0] pend;
    logic [15:0] w;
    bit          seen;
    exp_q.delete();
    exp_err = 0;
    seen    = 0;
    pend    = '0;
    for (int i = 1; i < slots.size() - 1; i++) begin
      w = exp_word(slots[i].len, slots[i].val);
      if (slots[i].ch == 1'b0) begin
        pend = w;
        seen = 1;
        if (slots[i].len < W) exp_err = exp_err + 1;
      end else if (seen) begin
        exp_q.push_back({pend, w});
        seen = 0;
        if (slots[i].len < W) exp_err = exp_err + 1;
      end
    end
  endtask

  task automatic check_results(input string tag);
    int n;
    chk({tag, "_pairs"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_pair"}, 64'(got_q[i]), 64'(exp_q[i]));
    chk({tag, "_frame_err"}, 64'(got_err), 64'(exp_err));
    foreach (lat_q[i]) chk({tag, "_latency"}, 64'(lat_q[i]), 64'd2);
    slots.delete();
    got_q.delete();
    lat_q.delete();
    got_err = 0;
  endtask

  task automatic do_reset();
    in_sck = 1'b0;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    got_err  = 0;
    rand_sck = 0;
    rst      = 1'b1;
    in_sck   = 1'b0;
    in_ws    = 1'b0;
    in_sd    = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_left",  64'(left_sample),  64'd0);
    chk("reset_right", 64'(right_sample), 64'd0);
    chk("reset_valid", 64'(sample_valid), 64'd0);
    chk("reset_err",   64'(frame_err),    64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 32-bit slots, garbage in the discarded low half
    add_slot(1, 32, $urandom);
    add_slot(0, 32, {16'h1234, 16'($urandom)});
    add_slot(1, 32, {16'hABCD, 16'($urandom)});
    add_slot(0, 32, {16'h8000, 16'($urandom)});
    add_slot(1, 32, {16'h7FFF, 16'($urandom)});
    add_slot(0, 32, $urandom);
    build_expect();
    chk("slot32_model0", 64'(exp_q[0]), 64'h1234ABCD);
    run_stream();
    check_results("slot32");

    do_reset();
    add_slot(1, 16, $urandom);
    add_slot(0, 16, 32'hFFFF);
    add_slot(1, 16, 32'h0001);
    add_slot(0, 16, $urandom);
    build_expect();
    run_stream();
    check_results("slot16");

    do_reset();
    add_slot(1, 8, $urandom);
    add_slot(0, 8, 32'hA5);
    add_slot(1, 8, 32'h3C);
    add_slot(0, 8, $urandom);
    build_expect();
    run_stream();
    chk("slot8_left",  64'(left_sample),  64'hA500);
    chk("slot8_right", 64'(right_sample), 64'h3C00);
    check_results("slot8");

    do_reset();
    add_slot(1, 5, $urandom);
    for (int i = 0; i < 5; i++) add_slot(i[0], 16, $urandom);
    build_expect();
    run_stream();
    check_results("mid_right");

    do_reset();
    rand_sck = 1;
    add_slot(1, int'($urandom_range(2, 32)), $urandom);
    for (int i = 0; i < 12; i++) add_slot(i[0], int'($urandom_range(10, 32)), $urandom);
    add_slot(0, 16, $urandom);
    build_expect();
    run_stream();
    check_results("random");
    rand_sck = 0;

    do_reset();
    add_slot(1, 16, $urandom);
    add_slot(0, 16, $urandom);
    add_slot(1, 16, $urandom);
    add_slot(0, 7, $urandom);
    build_expect();
    run_stream();
    check_results("pre_rst");
    do_reset();
    chk("rst_left",  64'(left_sample),  64'd0);
    chk("rst_right", 64'(right_sample), 64'd0);
    chk("rst_valid", 64'(sample_valid), 64'd0);
    add_slot(0, 9, $urandom);
    add_slot(1, 16, $urandom);
    add_slot(0, 16, $urandom);
    add_slot(1, 16, $urandom);
    add_slot(0, 16, $urandom);
    build_expect();
    run_stream();
    check_results("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
